// File: rtl/nw_vc_credit_return_pkg.sv
// Shared types and helpers for the VC credit-return block.
// Flit, channel-control and VC index types plus clogb2/oh2bin.
package nw_vc_credit_return_pkg;

    function automatic int clogb2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int NUM_VCS  = 4;
    localparam int VC_IDX_W = clogb2(NUM_VCS);
    localparam int DATA_W   = 32;

    typedef logic [VC_IDX_W-1:0] vc_index_t;

    typedef struct packed {
        logic [NUM_VCS-1:0] vc_id;
        logic               head;
        logic               tail;
    } flit_ctrl_t;

    typedef struct packed {
        flit_ctrl_t        control;
        logic [DATA_W-1:0] data;
    } flit_t;

    typedef struct packed {
        logic               credit_valid;
        vc_index_t          credit;
        logic [NUM_VCS-1:0] nearly_full;
    } chan_cntrl_t;

    function automatic vc_index_t oh2bin(input logic [NUM_VCS-1:0] oh);
        vc_index_t b;
        b = '0;
        for (int i = 0; i < NUM_VCS; i++)
            if (oh[i]) b = b | vc_index_t'(i);
        return b;
    endfunction

endpackage

// File: rtl/nw_vc_credit_return_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts after last winner.
// Pointer moves only when update is high and something was granted.
module nw_vc_credit_return_rr_arbiter
    import nw_vc_credit_return_pkg::*;
#(
    parameter int n = NUM_VCS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] req,
    input  logic         update,
    output logic [n-1:0] grant
);

    localparam int W = clogb2(n);

    logic [W-1:0] last_q;
    logic [W-1:0] gidx;
    logic         found;

    // Two passes: VCs above the last winner first, then wrap around.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int j = 0; j < n; j++) begin
            if (!found && req[j] && (j > int'(last_q))) begin
                grant[j] = 1'b1;
                gidx     = W'(j);
                found    = 1'b1;
            end
        end
        for (int j = 0; j < n; j++) begin
            if (!found && req[j] && (j <= int'(last_q))) begin
                grant[j] = 1'b1;
                gidx     = W'(j);
                found    = 1'b1;
            end
        end
    end

    // Last-winner pointer; reset value makes VC0 highest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= W'(n - 1);
        else if (update && found)
            last_q <= gidx;
    end

endmodule

// File: rtl/nw_vc_credit_return.sv
// Per-VC occupancy tracking and round-robin credit return upstream.
// One credit per valid pop, one credit returned per cycle at most.
module nw_vc_credit_return
    import nw_vc_credit_return_pkg::*;
#(
    parameter int num_vcs      = NUM_VCS,
    parameter int buf_len      = 4,
    parameter int counter_bits = clogb2(buf_len + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  flit_t                                 flit_in,
    input  logic                                  flit_in_valid,
    input  logic [num_vcs-1:0]                    vc_pop,
    output chan_cntrl_t                           channel_cntrl_out,
    output logic [num_vcs-1:0][counter_bits-1:0]  vc_occupancy,
    output logic                                  overflow_err,
    output logic                                  underflow_err
);

    localparam logic [counter_bits-1:0] FULL = counter_bits'(buf_len);
    localparam logic [counter_bits-1:0] NF   = counter_bits'(buf_len - 1);
    localparam logic [counter_bits-1:0] ONE  = counter_bits'(1);

    logic [num_vcs-1:0][counter_bits-1:0] occ_q, occ_d;
    logic [num_vcs-1:0][counter_bits-1:0] pend_q, pend_d;
    logic [num_vcs-1:0] arr, vpop, req, grant;
    logic [num_vcs-1:0] ovf, unf, nf_d, nf_q;
    logic               cv_q;
    vc_index_t          cr_q;
    logic               unused_flit;

    assign unused_flit = ^{flit_in.control.head,
                           flit_in.control.tail,
                           flit_in.data};

    // Occupancy update, error detection and credit requests per VC.
    always_comb begin
        arr   = '0;
        vpop  = '0;
        ovf   = '0;
        unf   = '0;
        req   = '0;
        nf_d  = '0;
        occ_d = occ_q;
        for (int v = 0; v < num_vcs; v++) begin
            arr[v]  = flit_in_valid & flit_in.control.vc_id[v];
            vpop[v] = vc_pop[v] & (arr[v] | (occ_q[v] != '0));
            ovf[v]  = arr[v] & ~vc_pop[v] & (occ_q[v] == FULL);
            unf[v]  = vc_pop[v] & ~arr[v] & (occ_q[v] == '0);
            if (arr[v] && !vc_pop[v] && !ovf[v])
                occ_d[v] = occ_q[v] + ONE;
            else if (!arr[v] && vc_pop[v] && !unf[v])
                occ_d[v] = occ_q[v] - ONE;
            nf_d[v] = (occ_d[v] >= NF);
            req[v]  = (pend_q[v] != '0) | vpop[v];
        end
    end

    // Owed credits: add valid pops, retire grants, saturate at buf_len.
    always_comb begin
        pend_d = pend_q;
        for (int v = 0; v < num_vcs; v++) begin
            if (vpop[v] && !grant[v])
                pend_d[v] = (pend_q[v] == FULL) ? pend_q[v]
                                                : pend_q[v] + ONE;
            else if (!vpop[v] && grant[v])
                pend_d[v] = pend_q[v] - ONE;
        end
    end

    nw_vc_credit_return_rr_arbiter #(
        .n (num_vcs)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .update (1'b1),
        .grant  (grant)
    );

    // State and registered credit/nearly-full outputs; errors are sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q         <= '0;
            pend_q        <= '0;
            cv_q          <= 1'b0;
            cr_q          <= '0;
            nf_q          <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            occ_q         <= occ_d;
            pend_q        <= pend_d;
            cv_q          <= |grant;
            cr_q          <= oh2bin(grant);
            nf_q          <= nf_d;
            overflow_err  <= overflow_err | (|ovf);
            underflow_err <= underflow_err | (|unf);
        end
    end

    assign channel_cntrl_out = '{credit_valid: cv_q,
                                 credit:       cr_q,
                                 nearly_full:  nf_q};
    assign vc_occupancy = occ_q;

endmodule
